viterbi_traceback: RTL and testbench

//  Downstream of the 64x4 survivor RAM. Accepts one per-state decision word per trellis step from the ACS,

---
 rtl/viterbi_pkg.sv | 22 ++
 rtl/tb_bit_buffer.sv | 26 ++
 rtl/viterbi_traceback.sv | 134 +++++++++++++
 tb/tb_viterbi_traceback.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi traceback block: trellis sizes, FSM encoding
// and the predecessor-state helper used during traceback.
package viterbi_pkg;

    localparam int NROWS     = 64;
    localparam int NBITS     = 4;
    localparam int ADDR_BITS = 6;
    localparam int SBITS     = 2;
    localparam int LEN_BITS  = ADDR_BITS + 1;

    typedef enum logic [1:0] {
        ST_WRITE = 2'd0,
        ST_TRACE = 2'd1,
        ST_EMIT  = 2'd2
    } tb_state_e;

    // State is {u_t, u_(t-1)}; walking back one step shifts the survivor bit in at the LSB.
    function automatic logic [SBITS-1:0] pred(input logic [SBITS-1:0] s, input logic b);
        return {s[SBITS-2:0], b};
    endfunction

endpackage

// File: rtl/tb_bit_buffer.sv
// Decoded-bit store: written out of order by the traceback, read in forward order on emit.
module tb_bit_buffer
    import viterbi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic                 i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic                 o_rdata
);

    logic [NROWS-1:0] r_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bits <= '0;
        end else if (i_we) begin
            r_bits[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_bits[i_raddr];

endmodule

// File: rtl/viterbi_traceback.sv
// Frame-based Viterbi traceback: stores ACS decisions in the survivor RAM, traces back
// from the supplied end state, then streams the decoded bits out in forward order.
//
// state    | meaning
// WRITE    | accepting decision words, one RAM write per handshake
// TRACE    | one RAM read per cycle walking tptr from len-1 down to 0
// EMIT     | presenting buffered bits on the out_valid/out_ready stream
module viterbi_traceback
    import viterbi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [NBITS-1:0]     dec,
    input  logic                 dec_last,
    input  logic [SBITS-1:0]     best_state,
    output logic                 rws,
    output logic                 cs,
    output logic [ADDR_BITS-1:0] cr,
    output logic [NBITS-1:0]     ram_din,
    input  logic [NBITS-1:0]     ram_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_bit,
    output logic                 out_last
);

    tb_state_e            r_state;
    logic [ADDR_BITS-1:0] r_wptr;
    logic [ADDR_BITS-1:0] r_tptr;
    logic [ADDR_BITS-1:0] r_eptr;
    logic [LEN_BITS-1:0]  r_len;
    logic [SBITS-1:0]     r_tstate;

    logic                 w_dec_hs;
    logic                 w_buf_bit;
    logic [ADDR_BITS-1:0] w_last_idx;
    logic                 w_at_last;

    assign w_dec_hs   = dec_valid && (r_state == ST_WRITE);
    assign w_last_idx = ADDR_BITS'(r_len - LEN_BITS'(1));
    assign w_at_last  = (r_eptr == w_last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_WRITE;
            r_wptr   <= '0;
            r_tptr   <= '0;
            r_eptr   <= '0;
            r_len    <= '0;
            r_tstate <= '0;
        end else begin
            case (r_state)
                ST_WRITE: begin
                    if (w_dec_hs) begin
                        // A full RAM closes the frame even without dec_last.
                        if (dec_last || (r_wptr == ADDR_BITS'(NROWS - 1))) begin
                            r_len    <= {1'b0, r_wptr} + LEN_BITS'(1);
                            r_tstate <= best_state;
                            r_tptr   <= r_wptr;
                            r_state  <= ST_TRACE;
                        end else begin
                            r_wptr <= r_wptr + ADDR_BITS'(1);
                        end
                    end
                end
                ST_TRACE: begin
                    r_tstate <= pred(r_tstate, ram_dout[r_tstate]);
                    if (r_tptr == '0) begin
                        r_eptr  <= '0;
                        r_state <= ST_EMIT;
                    end else begin
                        r_tptr <= r_tptr - ADDR_BITS'(1);
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (w_at_last) begin
                            r_wptr  <= '0;
                            r_state <= ST_WRITE;
                        end else begin
                            r_eptr <= r_eptr + ADDR_BITS'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_WRITE;
                end
            endcase
        end
    end

    // Decoded bit at each step is the MSB of the state being visited.
    tb_bit_buffer u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (r_state == ST_TRACE),
        .i_waddr (r_tptr),
        .i_wdata (r_tstate[SBITS-1]),
        .i_raddr (r_eptr),
        .o_rdata (w_buf_bit)
    );

    always_comb begin
        cs      = 1'b0;
        rws     = 1'b0;
        cr      = '0;
        ram_din = '0;
        case (r_state)
            ST_WRITE: begin
                if (dec_valid) begin
                    cs      = 1'b1;
                    rws     = 1'b1;
                    cr      = r_wptr;
                    ram_din = dec;
                end
            end
            ST_TRACE: begin
                cs = 1'b1;
                cr = r_tptr;
            end
            default: begin
                cs = 1'b0;
            end
        endcase
    end

    assign dec_ready = (r_state == ST_WRITE);
    assign out_valid = (r_state == ST_EMIT);
    assign out_bit   = out_valid && w_buf_bit;
    assign out_last  = out_valid && w_at_last;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback with a behavioural survivor RAM and a
// queue of expected decoded bits built from an independent traceback of the frame.
module tb_viterbi_traceback;
    import viterbi_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 dec_valid = 1'b0;
    logic                 dec_ready;
    logic [NBITS-1:0]     dec = '0;
    logic                 dec_last = 1'b0;
    logic [SBITS-1:0]     best_state = '0;
    logic                 rws;
    logic                 cs;
    logic [ADDR_BITS-1:0] cr;
    logic [NBITS-1:0]     ram_din;
    logic [NBITS-1:0]     ram_dout;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic                 out_bit;
    logic                 out_last;

    logic [NBITS-1:0] mem [NROWS];
    logic [NBITS-1:0] fr [NROWS];
    logic [SBITS-1:0] fbest;
    logic [1:0]       exp_q [$];
    int               n_vec = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    viterbi_traceback dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec        (dec),
        .dec_last   (dec_last),
        .best_state (best_state),
        .rws        (rws),
        .cs         (cs),
        .cr         (cr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .out_last   (out_last)
    );

    assign ram_dout = (cs && !rws) ? mem[cr] : '0;

    always @(posedge clk) begin
        if (cs && rws) mem[cr] <= ram_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference traceback over the frame array; pushes {bit,last} in forward order.
    task automatic push_expected(input int n);
        logic [SBITS-1:0] st;
        logic             bits [NROWS];
        logic [NBITS-1:0] row;
        st = fbest;
        for (int t = n - 1; t >= 0; t--) begin
            bits[t] = st[1];
            row     = fr[t];
            st      = {st[0], row[st]};
        end
        for (int t = 0; t < n; t++) exp_q.push_back({bits[t], (t == n - 1) ? 1'b1 : 1'b0});
    endtask

    task automatic write_frame(input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dec_valid  = 1'b1;
            dec        = fr[i];
            dec_last   = use_last && (i == n - 1);
            best_state = fbest;
            #1;
            chk("wr_ready", 32'(dec_ready), 32'd1);
            chk("wr_cs", 32'(cs), 32'd1);
            chk("wr_rws", 32'(rws), 32'd1);
            chk("wr_cr", 32'(cr), 32'(i));
            chk("wr_din", 32'(ram_din), 32'(fr[i]));
        end
    endtask

    task automatic trace_frame(input int n, input bit junk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dec_valid = junk;
            dec       = junk ? 4'hF : 4'h0;
            dec_last  = junk;
            #1;
            chk("tr_cs", 32'(cs), 32'd1);
            chk("tr_rws", 32'(rws), 32'd0);
            chk("tr_cr", 32'(cr), 32'(n - 1 - i));
            chk("tr_ready", 32'(dec_ready), 32'd0);
            chk("tr_ovalid", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic emit_frame(input int n, input int stall, input bit junk);
        logic [1:0] e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            if (k == 0 && stall > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    #1;
                    chk("bp_valid", 32'(out_valid), 32'd1);
                    chk("bp_bit", 32'(out_bit), 32'(e[1]));
                    chk("bp_last", 32'(out_last), 32'(e[0]));
                    chk("bp_ready", 32'(dec_ready), 32'd0);
                    chk("bp_cs", 32'(cs), 32'd0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            #1;
            chk("em_valid", 32'(out_valid), 32'd1);
            chk("em_bit", 32'(out_bit), 32'(e[1]));
            chk("em_last", 32'(out_last), 32'(e[0]));
            chk("em_cs", 32'(cs || (junk && rws)), 32'd0);
            chk("em_ready", 32'(dec_ready), 32'd0);
        end
        @(negedge clk);
        dec_valid = 1'b0;
        dec_last  = 1'b0;
        #1;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_ready", 32'(dec_ready), 32'd1);
    endtask

    task automatic run_frame(input int n, input bit use_last, input int stall, input bit junk);
        write_frame(n, use_last);
        push_expected(n);
        trace_frame(n, junk);
        emit_frame(n, stall, junk);
    endtask

    task automatic load_test2();
        fr[0] = 4'b0000; fr[1] = 4'b0000; fr[2] = 4'b0100; fr[3] = 4'b0000;
        fbest = 2'd3;
    endtask

    initial begin
        for (int i = 0; i < NROWS; i++) begin
            mem[i] = '0;
            fr[i]  = '0;
        end
        fbest = '0;
        #12;
        chk("rst_ready", 32'(dec_ready), 32'd1);
        chk("rst_cs", 32'(cs), 32'd0);
        chk("rst_cr", 32'(cr), 32'd0);
        chk("rst_din", 32'(ram_din), 32'd0);
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_obit", 32'(out_bit), 32'd0);
        chk("rst_olast", 32'(out_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full RAM closes the frame with no dec_last.
        fbest = 2'd0;
        run_frame(NROWS, 1'b0, 0, 1'b0);

        // Four-step frame, plain, then with dec_valid noise during trace/emit.
        load_test2();
        run_frame(4, 1'b1, 0, 1'b0);
        load_test2();
        run_frame(4, 1'b1, 0, 1'b1);

        // Single-step frame.
        fr[0] = 4'b1111;
        fbest = 2'd2;
        run_frame(1, 1'b1, 0, 1'b0);

        // Backpressure on the first output bit.
        load_test2();
        run_frame(4, 1'b1, 5, 1'b0);

        // Mixed pattern frame with varying data.
        for (int i = 0; i < 10; i++) fr[i] = 4'(i * 7 + 3);
        fbest = 2'd1;
        run_frame(10, 1'b1, 0, 1'b0);

        // Reset mid-trace of a full frame, then a clean short frame.
        for (int i = 0; i < NROWS; i++) fr[i] = 4'(i);
        fbest = 2'd0;
        write_frame(NROWS, 1'b0);
        @(negedge clk);
        dec_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_cs", 32'(cs), 32'd0);
        chk("mrst_ovalid", 32'(out_valid), 32'd0);
        chk("mrst_ready", 32'(dec_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        load_test2();
        run_frame(4, 1'b1, 0, 1'b0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
